fp_addmul_unit: RTL and testbench

Parametrised floating-point add/subtract/multiply unit. It is the self-sequenced successor to the testbench-driven add/mul datapath: an internal FSM replaces the externally driven shift/mux/load controls. It accepts one operation per start/done handshake and returns a packed IEEE-style result. Field widths are configurable. Rounding is round-to-nearest-even. Sign, zero, overflow and underflow are handled explicitly.

---
 rtl/fp_addmul_unit_if.sv | 28 ++
 rtl/fp_addmul_unit.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fp_addmul_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fp_addmul_unit_if.sv
// Handshake and data bundle for fp_addmul_unit.
// The master side issues operations; the slave side (the unit) returns results.
interface fp_addmul_unit_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) ();
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, overflow, underflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, overflow, underflow
  );
endinterface

// File: rtl/fp_addmul_unit.sv
// Self-sequenced floating-point add/subtract/multiply unit.
// One operation per start/done handshake, fixed five-cycle latency, round to
// nearest even, denormal inputs flushed to zero, overflow saturates to
// infinity and exponent underflow flushes to signed zero.
module fp_addmul_unit #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int GRS_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  fp_addmul_unit_if.slave   bus
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int M   = FRAC_W + 1;          // mantissa including hidden bit
  localparam int WX  = M + GRS_W;           // mantissa plus guard/round/sticky
  localparam int WS  = WX + 1;              // plus carry-out position
  localparam int EW  = EXP_W + 2;           // signed internal exponent width
  localparam int LZW = $clog2(WX + 1);

  localparam logic signed [EW-1:0] BIAS     = EW'((32'sd1 <<< (EXP_W - 1)) - 32'sd1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((32'sd1 <<< EXP_W) - 32'sd1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(32'sd1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(32'sd0);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UNPACK    = 3'd1,
    ST_OPERATE   = 3'd2,
    ST_NORMALIZE = 3'd3,
    ST_ROUND     = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  // Leading-zero count of a WX-bit mantissa (returns WX for an all-zero input).
  function automatic logic [LZW-1:0] lzc_f(input logic [WX-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = WX - 1; i >= 0; i--) begin
      if (found) begin
        n = n;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        n = n + 1'b1;
      end
    end
    return n;
  endfunction

  // Right-shift with sticky: every bit shifted out is ORed into the LSB.
  function automatic logic [WX-1:0] align_f(input logic [WX-1:0] v,
                                            input logic [EXP_W-1:0] sh);
    logic [WX-1:0] kept;
    logic [WX-1:0] lost_mask;
    logic          sticky;
    if (32'(sh) >= WX) begin
      kept   = '0;
      sticky = |v;
    end else begin
      kept      = v >> sh;
      lost_mask = ~({WX{1'b1}} << sh);
      sticky    = |(v & lost_mask);
    end
    return {kept[WX-1:1], kept[0] | sticky};
  endfunction

  // Pipeline / sequencing state
  state_t                 state_r;
  logic [W-1:0]           a_r;
  logic [W-1:0]           b_r;
  logic [1:0]             op_r;
  logic                   is_mul_r;
  logic                   eff_sub_r;
  logic                   sign_r;
  logic signed [EW-1:0]   exp_r;
  logic [WX-1:0]          x_man_r;
  logic [WX-1:0]          y_man_r;
  logic [WS-1:0]          raw_man_r;
  logic [WX-1:0]          norm_man_r;
  logic                   zero_r;

  // Unpack-stage signals
  logic                   a_sign_s, b_sign_s, b_eff_sign_s;
  logic                   a_zero_s, b_zero_s, is_sub_s, is_mul_s, a_ge_b_s;
  logic [EXP_W-1:0]       a_exp_s, b_exp_s, exp_diff_s;
  logic [M-1:0]           a_man_s, b_man_s;
  logic [W-2:0]           a_mag_s, b_mag_s;
  logic [WX-1:0]          y_pre_s, y_aligned_s;
  logic signed [EW-1:0]   mul_exp_s;

  // Operate-stage signals
  logic [2*M-1:0]         prod_s;
  logic [WS-1:0]          mul_res_s;
  logic [WS-1:0]          add_res_s;

  // Normalize-stage signals
  logic [LZW-1:0]         lz_s;
  logic [WX-1:0]          norm_s;
  logic signed [EW-1:0]   norm_exp_s;

  // Round/pack signals
  logic [M-1:0]           mant_s;
  logic                   guard_s, rs_s, inc_s;
  logic [M:0]             rnd_s;
  logic [FRAC_W-1:0]      frac_s;
  logic signed [EW-1:0]   fin_exp_s;
  logic [W-1:0]           res_s;
  logic                   ovf_s, unf_s;

  // Decode captured operands, pick the larger-magnitude addend and align the other.
  always_comb begin
    a_sign_s     = a_r[W-1];
    b_sign_s     = b_r[W-1];
    a_exp_s      = a_r[W-2:FRAC_W];
    b_exp_s      = b_r[W-2:FRAC_W];
    a_zero_s     = (a_exp_s == {EXP_W{1'b0}});
    b_zero_s     = (b_exp_s == {EXP_W{1'b0}});
    a_man_s      = a_zero_s ? {M{1'b0}} : {1'b1, a_r[FRAC_W-1:0]};
    b_man_s      = b_zero_s ? {M{1'b0}} : {1'b1, b_r[FRAC_W-1:0]};
    a_mag_s      = a_zero_s ? {(W-1){1'b0}} : a_r[W-2:0];
    b_mag_s      = b_zero_s ? {(W-1){1'b0}} : b_r[W-2:0];
    is_sub_s     = (op_r == 2'b01);
    is_mul_s     = (op_r == 2'b10);
    b_eff_sign_s = b_sign_s ^ is_sub_s;
    a_ge_b_s     = (a_mag_s >= b_mag_s);
    if (a_ge_b_s) begin
      exp_diff_s = a_exp_s - b_exp_s;
      y_pre_s    = {b_man_s, {GRS_W{1'b0}}};
    end else begin
      exp_diff_s = b_exp_s - a_exp_s;
      y_pre_s    = {a_man_s, {GRS_W{1'b0}}};
    end
    y_aligned_s = align_f(y_pre_s, exp_diff_s);
    mul_exp_s   = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s}) - BIAS;
  end

  // Mantissa arithmetic: aligned add/subtract and full-width product folded to WS bits.
  always_comb begin
    prod_s    = {{M{1'b0}}, x_man_r[WX-1:GRS_W]} * {{M{1'b0}}, y_man_r[WX-1:GRS_W]};
    mul_res_s = {prod_s[2*M-1 -: WS-1], prod_s[2*M-WS] | (|prod_s[2*M-WS-1:0])};
    if (eff_sub_r) begin
      add_res_s = {1'b0, x_man_r} - {1'b0, y_man_r};
    end else begin
      add_res_s = {1'b0, x_man_r} + {1'b0, y_man_r};
    end
  end

  // Normalisation: carry-out shifts right by one, otherwise left by the leading-zero count.
  always_comb begin
    lz_s = lzc_f(raw_man_r[WX-1:0]);
    if (raw_man_r[WS-1]) begin
      norm_s     = {raw_man_r[WS-1:2], raw_man_r[1] | raw_man_r[0]};
      norm_exp_s = exp_r + EXP_ONE;
    end else begin
      norm_s     = raw_man_r[WX-1:0] << lz_s;
      norm_exp_s = exp_r - $signed({{(EW-LZW){1'b0}}, lz_s});
    end
  end

  // Round to nearest even, then saturate/flush and pack the final word.
  always_comb begin
    mant_s  = norm_man_r[WX-1:GRS_W];
    guard_s = norm_man_r[GRS_W-1];
    rs_s    = |norm_man_r[GRS_W-2:0];
    inc_s   = guard_s & (rs_s | mant_s[0]);
    rnd_s   = {1'b0, mant_s} + {{M{1'b0}}, inc_s};
    if (rnd_s[M]) begin
      frac_s    = rnd_s[FRAC_W:1];
      fin_exp_s = exp_r + EXP_ONE;
    end else begin
      frac_s    = rnd_s[FRAC_W-1:0];
      fin_exp_s = exp_r;
    end
    if (zero_r) begin
      res_s = {sign_r, {(W-1){1'b0}}};
      ovf_s = 1'b0;
      unf_s = 1'b0;
    end else if (fin_exp_s >= EXP_MAX) begin
      res_s = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_s = 1'b1;
      unf_s = 1'b0;
    end else if (fin_exp_s <= EXP_ZERO) begin
      res_s = {sign_r, {(W-1){1'b0}}};
      ovf_s = 1'b0;
      unf_s = 1'b1;
    end else begin
      res_s = {sign_r, fin_exp_s[EXP_W-1:0], frac_s};
      ovf_s = 1'b0;
      unf_s = 1'b0;
    end
  end

  // Sequencer: steps one stage per cycle; outputs are registered and held until the next done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      a_r           <= '0;
      b_r           <= '0;
      op_r          <= 2'b00;
      is_mul_r      <= 1'b0;
      eff_sub_r     <= 1'b0;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      x_man_r       <= '0;
      y_man_r       <= '0;
      raw_man_r     <= '0;
      norm_man_r    <= '0;
      zero_r        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            op_r     <= bus.op;
            bus.busy <= 1'b1;
            state_r  <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          is_mul_r <= is_mul_s;
          if (is_mul_s) begin
            x_man_r   <= {a_man_s, {GRS_W{1'b0}}};
            y_man_r   <= {b_man_s, {GRS_W{1'b0}}};
            exp_r     <= mul_exp_s;
            sign_r    <= a_sign_s ^ b_sign_s;
            eff_sub_r <= 1'b0;
          end else begin
            x_man_r   <= a_ge_b_s ? {a_man_s, {GRS_W{1'b0}}} : {b_man_s, {GRS_W{1'b0}}};
            y_man_r   <= y_aligned_s;
            exp_r     <= a_ge_b_s ? $signed({2'b00, a_exp_s}) : $signed({2'b00, b_exp_s});
            sign_r    <= a_ge_b_s ? a_sign_s : b_eff_sign_s;
            eff_sub_r <= a_sign_s ^ b_eff_sign_s;
          end
          state_r <= ST_OPERATE;
        end
        ST_OPERATE: begin
          raw_man_r <= is_mul_r ? mul_res_s : add_res_s;
          // An exact cancellation is reported as +0 regardless of operand signs.
          if (!is_mul_r && eff_sub_r && (add_res_s == {WS{1'b0}})) begin
            sign_r <= 1'b0;
          end
          state_r <= ST_NORMALIZE;
        end
        ST_NORMALIZE: begin
          norm_man_r <= norm_s;
          exp_r      <= norm_exp_s;
          zero_r     <= (raw_man_r == {WS{1'b0}});
          state_r    <= ST_ROUND;
        end
        ST_ROUND: begin
          // Rounding and final packing land in the output registers as FINISH is entered.
          bus.result    <= res_s;
          bus.overflow  <= ovf_s;
          bus.underflow <= unf_s;
          bus.done      <= 1'b1;
          state_r       <= ST_FINISH;
        end
        ST_FINISH: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addmul_unit.sv
// Directed bench for fp_addmul_unit: single-precision instance plus a
// half-width (EXP_W=5, FRAC_W=10) instance.
module tb_fp_addmul_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   d0, d1;

  fp_addmul_unit_if #(.EXP_W(8), .FRAC_W(23)) bus32 ();
  fp_addmul_unit_if #(.EXP_W(5), .FRAC_W(10)) bus16 ();

  fp_addmul_unit #(.EXP_W(8), .FRAC_W(23), .GRS_W(3)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  fp_addmul_unit #(.EXP_W(5), .FRAC_W(10), .GRS_W(3)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Issue one operation in the current cycle (T); returns in cycle T+6.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ovf,
                        input logic exp_unf, output int done_cyc);
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    bus32.start = 1'b1;
    tick();                                  // T+1
    bus32.start = 1'b0;
    bus32.a     = ~a;
    bus32.b     = ~b;
    bus32.op    = ~op;
    chk1({tag, ":busy_t1"}, bus32.busy, 1'b1);
    chk1({tag, ":done_t1"}, bus32.done, 1'b0);
    repeat (3) tick();                       // T+4
    chk1({tag, ":busy_t4"}, bus32.busy, 1'b1);
    chk1({tag, ":done_t4"}, bus32.done, 1'b0);
    tick();                                  // T+5
    done_cyc = cyc;
    chk1({tag, ":done_t5"}, bus32.done, 1'b1);
    chk1({tag, ":busy_t5"}, bus32.busy, 1'b1);
    chk32({tag, ":result"}, bus32.result, exp_res);
    chk1({tag, ":overflow"}, bus32.overflow, exp_ovf);
    chk1({tag, ":underflow"}, bus32.underflow, exp_unf);
    tick();                                  // T+6
    chk1({tag, ":done_t6"}, bus32.done, 1'b0);
    chk1({tag, ":busy_t6"}, bus32.busy, 1'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    reset       = 1'b1;
    bus32.start = 1'b0;
    bus32.op    = 2'b00;
    bus32.a     = 32'h0;
    bus32.b     = 32'h0;
    bus16.start = 1'b0;
    bus16.op    = 2'b00;
    bus16.a     = 16'h0;
    bus16.b     = 16'h0;
    tick();
    tick();
    chk1("rst:busy", bus32.busy, 1'b0);
    chk1("rst:done", bus32.done, 1'b0);
    chk32("rst:result", bus32.result, 32'h0);
    chk1("rst:overflow", bus32.overflow, 1'b0);
    chk1("rst:underflow", bus32.underflow, 1'b0);
    reset = 1'b0;
    tick();

    // Arithmetic; the first two also form a back-to-back pair.
    run_op("add_1p5_2p25", 2'b00, 32'h3FC00000, 32'h40100000, 32'h40700000, 1'b0, 1'b0, d0);
    run_op("sub_3_1",      2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, d1);
    chk32("b2b_spacing", 32'(d1 - d0), 32'd6);
    run_op("sub_equal",    2'b01, 32'h41200000, 32'h41200000, 32'h00000000, 1'b0, 1'b0, d0);
    run_op("mul_1p5_2p5",  2'b10, 32'h3FC00000, 32'h40200000, 32'h40700000, 1'b0, 1'b0, d0);
    run_op("mul_neg2_1",   2'b10, 32'hC0000000, 32'h3F800000, 32'hC0000000, 1'b0, 1'b0, d0);
    run_op("tie_even",     2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0, d0);
    run_op("tie_up",       2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0, d0);
    run_op("mul_ovf",      2'b10, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, d0);
    run_op("mul_unf",      2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, d0);
    run_op("rsvd_as_add",  2'b11, 32'h3FC00000, 32'h40100000, 32'h40700000, 1'b0, 1'b0, d0);

    // Reset during the NORMALIZE cycle aborts the operation.
    run_op("pre_abort",    2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, d0);
    bus32.op    = 2'b00;
    bus32.a     = 32'h3FC00000;
    bus32.b     = 32'h40100000;
    bus32.start = 1'b1;
    tick();                                  // T+1
    bus32.start = 1'b0;
    tick();                                  // T+2
    tick();                                  // T+3
    reset = 1'b1;
    tick();                                  // T+4
    reset = 1'b0;
    chk1("abort:busy", bus32.busy, 1'b0);
    chk1("abort:done", bus32.done, 1'b0);
    chk32("abort:result", bus32.result, 32'h0);
    chk1("abort:underflow", bus32.underflow, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("abort:no_done", bus32.done, 1'b0);
    end

    // start while busy is ignored.
    bus32.op    = 2'b00;
    bus32.a     = 32'h3FC00000;
    bus32.b     = 32'h40100000;
    bus32.start = 1'b1;
    tick();                                  // T+1
    bus32.start = 1'b0;
    tick();                                  // T+2
    bus32.op    = 2'b01;
    bus32.a     = 32'h40400000;
    bus32.b     = 32'h3F800000;
    bus32.start = 1'b1;
    tick();                                  // T+3
    bus32.start = 1'b0;
    tick();                                  // T+4
    chk1("ignore:done_t4", bus32.done, 1'b0);
    tick();                                  // T+5
    chk1("ignore:done_t5", bus32.done, 1'b1);
    chk32("ignore:result", bus32.result, 32'h40700000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("ignore:no_extra_done", bus32.done, 1'b0);
      chk1("ignore:idle", bus32.busy, 1'b0);
    end

    // Half-width instance: 1.5 + 2.25.
    bus16.op    = 2'b00;
    bus16.a     = 16'h3E00;
    bus16.b     = 16'h4080;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    chk1("h_add:busy_t1", bus16.busy, 1'b1);
    repeat (4) tick();
    chk1("h_add:done_t5", bus16.done, 1'b1);
    chk32("h_add:result", {16'h0, bus16.result}, 32'h00004380);
    chk1("h_add:overflow", bus16.overflow, 1'b0);
    tick();
    chk1("h_add:done_t6", bus16.done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
